// File: rtl/dcache_line_fill_pkg.sv
// Shared constants and FSM state type for the direct-mapped line-fill data cache.
package dcache_line_fill_pkg;

  localparam int unsigned WORDS_PER_LINE = 16;
  localparam int unsigned WORD_W         = 32;
  localparam int unsigned OFF_BITS       = 4;
  localparam int unsigned OFFSET_LSB     = 2;
  localparam int unsigned INDEX_LSB      = 6;
  localparam int unsigned LINE_W         = WORDS_PER_LINE * WORD_W;

  typedef enum logic {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

endpackage

// File: rtl/dcache_line_store.sv
// Tag/valid/data array: combinational read, single-word write, full-line fill with valid-set.
module dcache_line_store
  import dcache_line_fill_pkg::*;
#(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IDX_BITS  = 2,
  parameter int unsigned TAG_W     = 32 - INDEX_LSB - IDX_BITS
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] rd_idx,
  input  logic [OFF_BITS-1:0] rd_off,
  output logic                rd_valid,
  output logic [TAG_W-1:0]    rd_tag,
  output logic [WORD_W-1:0]   rd_word,
  input  logic                wr_en,
  input  logic [IDX_BITS-1:0] wr_idx,
  input  logic [OFF_BITS-1:0] wr_off,
  input  logic [WORD_W-1:0]   wr_data,
  input  logic                fill_en,
  input  logic [IDX_BITS-1:0] fill_idx,
  input  logic [TAG_W-1:0]    fill_tag,
  input  logic [LINE_W-1:0]   fill_line
);

  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [WORD_W-1:0]    data_q [NUM_LINES][WORDS_PER_LINE];
  logic [WORD_W-1:0]    data_d [NUM_LINES][WORDS_PER_LINE];

  always_comb begin
    valid_d = valid_q;
    tag_d   = tag_q;
    data_d  = data_q;
    if (fill_en) begin
      valid_d[fill_idx] = 1'b1;
      tag_d[fill_idx]   = fill_tag;
      for (int unsigned w = 0; w < WORDS_PER_LINE; w++) begin
        data_d[fill_idx][w] = fill_line[w*WORD_W +: WORD_W];
      end
    end
    if (wr_en) begin
      data_d[wr_idx][wr_off] = wr_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  // Tag and data contents are meaningless while invalid, so they carry no reset.
  always_ff @(posedge clk) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign rd_valid = valid_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_word  = data_q[rd_idx][rd_off];

endmodule

// File: rtl/dcache_line_fill.sv
// Direct-mapped write-through, no-write-allocate data cache with a timed 16-word line fill.
module dcache_line_fill
  import dcache_line_fill_pkg::*;
#(
  parameter int unsigned NUM_LINES = 4,
  parameter int unsigned IDX_BITS  = 2,
  parameter int unsigned FILL_LAT  = 2
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic              CpuRE,
  input  logic              CpuWE,
  input  logic [31:0]       CpuA,
  input  logic [31:0]       CpuWD,
  output logic [31:0]       CpuRD,
  output logic              Stall,
  output logic              MemWE,
  output logic [31:0]       MemWA,
  output logic [31:0]       MemWD,
  output logic [31:0]       CacheRA,
  input  logic [LINE_W-1:0] CacheLine
);

  localparam int unsigned TAG_LSB = INDEX_LSB + IDX_BITS;
  localparam int unsigned TAG_W   = 32 - TAG_LSB;
  localparam int unsigned CNT_W   = (FILL_LAT > 1) ? $clog2(FILL_LAT) : 1;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        miss_base_q, miss_base_d;

  logic [IDX_BITS-1:0] idx, miss_idx;
  logic [OFF_BITS-1:0] off;
  logic [TAG_W-1:0]    tag, miss_tag, line_tag;
  logic                line_valid;
  logic [WORD_W-1:0]   line_word;
  logic                tag_match, store_req, load_req, load_hit, load_miss, fill_done;
  logic                unused_addr_bits;

  assign idx              = CpuA[INDEX_LSB +: IDX_BITS];
  assign off              = CpuA[OFFSET_LSB +: OFF_BITS];
  assign tag              = CpuA[31:TAG_LSB];
  assign miss_idx         = miss_base_q[INDEX_LSB +: IDX_BITS];
  assign miss_tag         = miss_base_q[31:TAG_LSB];
  assign unused_addr_bits = ^CpuA[1:0];

  always_comb begin
    tag_match = line_valid && (line_tag == tag);
    store_req = (state_q == IDLE) && CpuWE;
    load_req  = (state_q == IDLE) && CpuRE && !CpuWE;
    load_hit  = load_req && tag_match;
    load_miss = load_req && !tag_match;
    fill_done = (state_q == FILL) && (cnt_q == '0);

    state_d     = state_q;
    cnt_d       = cnt_q;
    miss_base_d = miss_base_q;
    if (state_q == IDLE) begin
      if (load_miss) begin
        state_d     = FILL;
        cnt_d       = CNT_W'(FILL_LAT - 1);
        miss_base_d = {CpuA[31:6], 6'b0};
      end
    end else if (fill_done) begin
      state_d = IDLE;
    end else begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      miss_base_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      miss_base_q <= miss_base_d;
    end
  end

  // Outputs are gated by RST_N so an aborted fill drops Stall immediately, even with CpuRE held.
  always_comb begin
    CpuRD   = (RST_N && load_hit) ? line_word : '0;
    Stall   = RST_N && (load_miss || (state_q == FILL));
    MemWE   = RST_N && store_req;
    MemWA   = MemWE ? CpuA  : '0;
    MemWD   = MemWE ? CpuWD : '0;
    CacheRA = miss_base_q;
  end

  dcache_line_store #(
    .NUM_LINES (NUM_LINES),
    .IDX_BITS  (IDX_BITS),
    .TAG_W     (TAG_W)
  ) u_store (
    .clk       (CLK),
    .rst_n     (RST_N),
    .rd_idx    (idx),
    .rd_off    (off),
    .rd_valid  (line_valid),
    .rd_tag    (line_tag),
    .rd_word   (line_word),
    .wr_en     (store_req && tag_match),
    .wr_idx    (idx),
    .wr_off    (off),
    .wr_data   (CpuWD),
    .fill_en   (fill_done),
    .fill_idx  (miss_idx),
    .fill_tag  (miss_tag),
    .fill_line (CacheLine)
  );

endmodule

// File: tb/tb_dcache_line_fill.sv
// Self-checking bench: data_mem model, per-cycle behavioural cache model, directed and random loads/stores.
module tb_dcache_line_fill;

  localparam int unsigned FILL_LAT = 2;
  localparam int unsigned NLINES   = 4;
  localparam int unsigned MEMW     = 512;

  logic         CLK, RST_N, CpuRE, CpuWE, Stall, MemWE;
  logic [31:0]  CpuA, CpuWD, CpuRD, MemWA, MemWD, CacheRA;
  logic [511:0] CacheLine;

  int total = 0;
  int bad   = 0;

  dcache_line_fill #(
    .NUM_LINES (NLINES),
    .IDX_BITS  (2),
    .FILL_LAT  (FILL_LAT)
  ) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CpuRE     (CpuRE),
    .CpuWE     (CpuWE),
    .CpuA      (CpuA),
    .CpuWD     (CpuWD),
    .CpuRD     (CpuRD),
    .Stall     (Stall),
    .MemWE     (MemWE),
    .MemWA     (MemWA),
    .MemWD     (MemWD),
    .CacheRA   (CacheRA),
    .CacheLine (CacheLine)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // data_mem: single write port, 16-word line read port addressed by CacheRA
  logic [31:0] mem [MEMW];
  always @(posedge CLK) if (MemWE === 1'b1) mem[MemWA[10:2]] <= MemWD;
  always_comb begin
    CacheLine = '0;
    for (int i = 0; i < 16; i++) CacheLine[i*32 +: 32] = mem[(int'(CacheRA[10:2]) + i) % MEMW];
  end

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Behavioural model: what the cache holds, how many fill cycles remain, last miss line base
  bit          m_valid [NLINES];
  logic [31:0] m_tag   [NLINES];
  logic [31:0] m_data  [NLINES][16];
  int          m_rem;
  logic [31:0] m_base;

  function automatic int line_of(input logic [31:0] a); return int'((a >> 6) % NLINES); endfunction
  function automatic int word_of(input logic [31:0] a); return int'((a >> 2) % 16); endfunction
  function automatic bit present(input logic [31:0] a);
    return m_valid[line_of(a)] && (m_tag[line_of(a)] == (a >> 8));
  endfunction

  always @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      for (int i = 0; i < NLINES; i++) m_valid[i] <= 1'b0;
      m_rem  <= 0;
      m_base <= '0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) begin
        m_valid[line_of(m_base)] <= 1'b1;
        m_tag[line_of(m_base)]   <= m_base >> 8;
        for (int w = 0; w < 16; w++)
          m_data[line_of(m_base)][w] <= mem[(int'(m_base >> 2) + w) % MEMW];
      end
    end else if (CpuWE) begin
      if (present(CpuA)) m_data[line_of(CpuA)][word_of(CpuA)] <= CpuWD;
    end else if (CpuRE && !present(CpuA)) begin
      m_rem  <= FILL_LAT;
      m_base <= CpuA & ~32'h3F;
    end
  end

  always @(negedge CLK) begin
    bit filling, exp_stall;
    if (!RST_N) begin
      check("rst_Stall",   {31'b0, Stall}, 32'd0);
      check("rst_CpuRD",   CpuRD,   32'd0);
      check("rst_MemWE",   {31'b0, MemWE}, 32'd0);
      check("rst_MemWA",   MemWA,   32'd0);
      check("rst_MemWD",   MemWD,   32'd0);
      check("rst_CacheRA", CacheRA, 32'd0);
    end else begin
      filling   = (m_rem > 0);
      exp_stall = filling || (CpuRE && !CpuWE && !present(CpuA));
      check("Stall",   {31'b0, Stall}, {31'b0, exp_stall});
      check("CacheRA", CacheRA, m_base);
      check("MemWE",   {31'b0, MemWE}, {31'b0, !filling && CpuWE});
      if (!filling && CpuWE) begin
        check("MemWA", MemWA, CpuA);
        check("MemWD", MemWD, CpuWD);
      end
      if (!exp_stall)
        check("CpuRD", CpuRD, (CpuRE && !CpuWE) ? m_data[line_of(CpuA)][word_of(CpuA)] : 32'd0);
    end
  end

  // Issue one request and hold it while the cache stalls; report what the CPU saw.
  task automatic op(input logic re, input logic we, input logic [31:0] a, input logic [31:0] wd,
                    output int stalls, output logic [31:0] rd, output logic [31:0] cra,
                    output logic mwe, output logic [31:0] mwa, output logic [31:0] mwd);
    bit done = 0;
    @(posedge CLK); #1;
    CpuRE = re; CpuWE = we; CpuA = a; CpuWD = wd;
    stalls = 0; rd = 'x; cra = 'x;
    for (int k = 0; k < 40; k++) begin
      @(negedge CLK);
      if (k == 0) begin mwe = MemWE; mwa = MemWA; mwd = MemWD; end
      if (Stall) begin
        stalls++;
        cra = CacheRA;
        @(posedge CLK); #1;
      end else begin
        rd = CpuRD;
        done = 1;
        break;
      end
    end
    if (!done) check("stall_timeout", 32'd1, 32'd0);
  endtask

  int          st;
  logic [31:0] rd, cra, mwa, mwd;
  logic        mwe;

  initial begin
    RST_N = 1'b0; CpuRE = 1'b0; CpuWE = 1'b0; CpuA = '0; CpuWD = '0;
    for (int i = 0; i < MEMW; i++) mem[i] = $urandom;
    mem[16] = 32'hDEADBEEF;
    mem[31] = 32'hCAFE0031;
    mem[80] = 32'h01400140;
    repeat (2) @(posedge CLK);
    #2 RST_N = 1'b1;
    #1 check("post_rst_CacheRA", CacheRA, 32'h0);

    op(1, 0, 32'h40, 0, st, rd, cra, mwe, mwa, mwd);
    check("miss40_stalls", st, 3);
    check("miss40_CacheRA", cra, 32'h40);
    check("miss40_data", rd, 32'hDEADBEEF);

    op(1, 0, 32'h7C, 0, st, rd, cra, mwe, mwa, mwd);
    check("hit7C_stalls", st, 0);
    check("hit7C_data", rd, 32'hCAFE0031);

    op(0, 1, 32'h44, 32'h12345678, st, rd, cra, mwe, mwa, mwd);
    check("st44_stalls", st, 0);
    check("st44_MemWE", {31'b0, mwe}, 32'd1);
    check("st44_MemWA", mwa, 32'h44);
    check("st44_MemWD", mwd, 32'h12345678);
    op(1, 0, 32'h44, 0, st, rd, cra, mwe, mwa, mwd);
    check("ld44_stalls", st, 0);
    check("ld44_data", rd, 32'h12345678);

    op(0, 1, 32'h400, 32'hA5A50400, st, rd, cra, mwe, mwa, mwd);
    check("st400_stalls", st, 0);
    check("st400_MemWE", {31'b0, mwe}, 32'd1);
    op(1, 0, 32'h400, 0, st, rd, cra, mwe, mwa, mwd);
    check("ld400_stalls", st, 3);
    check("ld400_data", rd, 32'hA5A50400);

    @(posedge CLK); #1 CpuRE = 0; CpuWE = 0; RST_N = 1'b0;
    @(posedge CLK); #2 RST_N = 1'b1;
    op(1, 0, 32'h40, 0, st, rd, cra, mwe, mwa, mwd);
    check("conf1_stalls", st, 3);
    op(1, 0, 32'h140, 0, st, rd, cra, mwe, mwa, mwd);
    check("conf2_stalls", st, 3);
    check("conf2_data", rd, 32'h01400140);
    op(1, 0, 32'h40, 0, st, rd, cra, mwe, mwa, mwd);
    check("conf3_stalls", st, 3);
    check("conf3_data", rd, 32'hDEADBEEF);

    // Abort a fill with reset during its second FILL cycle
    @(posedge CLK); #1 CpuRE = 1; CpuWE = 0; CpuA = 32'h140;
    @(posedge CLK);
    @(posedge CLK); #2 check("fill2_Stall", {31'b0, Stall}, 32'd1);
    #1 RST_N = 1'b0; CpuRE = 0;
    #1 check("abort_Stall", {31'b0, Stall}, 32'd0);
    check("abort_CacheRA", CacheRA, 32'h0);
    @(negedge CLK); #2 RST_N = 1'b1;
    op(1, 0, 32'h140, 0, st, rd, cra, mwe, mwa, mwd);
    check("reissue_stalls", st, 3);
    check("reissue_data", rd, 32'h01400140);

    for (int n = 0; n < 400; n++) begin
      int unsigned r = $urandom_range(0, 9);
      logic [31:0] a = (($urandom_range(0, 3) == 0) ? $urandom_range(0, MEMW - 1)
                                                    : $urandom_range(0, 127)) << 2;
      a = a | 32'($urandom_range(0, 3));
      op(r < 5 || r == 8, r >= 5 && r < 9, a, $urandom, st, rd, cra, mwe, mwa, mwd);
    end

    @(posedge CLK); #1 CpuRE = 0; CpuWE = 0;
    repeat (3) @(posedge CLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/dcache_line_fill.md
Name: dcache_line_fill

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the MEM stage and data_mem.
- Serves CPU loads from local line storage.
- On a miss, issues a line-base address on CacheRA and captures the 16-word line returned by data_mem's CacheRD0..CacheRD15 ports after a programmable fill latency.
- Stores pass straight through to data_mem's single write port and also update the cached copy on a hit.

Parameters:
- NUM_LINES, 4, number of cache lines; power of two, >= 2.
- IDX_BITS, 2, log2(NUM_LINES).
- FILL_LAT, 2, cycles data_mem needs before the CacheRD bus is valid; >= 1.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  reset.
- CpuRE  in  1  load request.
- CpuWE  in  1  store request.
- CpuA  in  32  byte address; bits [1:0] ignored.
- CpuWD  in  32  store data.
- CpuRD  out  32  load data.
- Stall  out  1  pipeline hold; CPU holds CpuRE, CpuWE, CpuA and CpuWD stable while it is 1.
- MemWE  out  1  to data_mem WE.
- MemWA  out  32  to data_mem WA.
- MemWD  out  32  to data_mem WD.
- CacheRA  out  32  to data_mem CacheRA; line base address.
- CacheLine  in  512  {CacheRD15,...,CacheRD0}; CacheRD0 occupies [31:0].

Interface decision: one clock; reset is asynchronous and active-low. The reset port is RST_N.

Behaviour:
- Address split:
  - offset = CpuA[5:2]
  - index = CpuA[6+IDX_BITS-1:6]
  - tag = CpuA[31:6+IDX_BITS]
- Storage: per line, 1 valid bit, a tag, and 16x32 data words.
- Reset (asynchronous, RST_N=0):
  - all valid bits = 0, state = IDLE, fill counter = 0.
  - CpuRD = 0, Stall = 0, MemWE = 0, MemWA = 0, MemWD = 0, CacheRA = 0.
  - Data/tag arrays are not reset.
- hit = CpuRE & valid[index] & (tag_store[index] == tag).
- FSM states: IDLE, FILL.
- IDLE:
  - Read hit: CpuRD = word[index][offset] combinationally, same cycle. Stall = 0.
  - Read miss: Stall = 1 combinationally. On the next edge: state -> FILL, latch miss_base = {CpuA[31:6],6'b0}, counter = FILL_LAT-1.
  - Store (CpuWE=1): MemWE = 1, MemWA = CpuA, MemWD = CpuWD, combinational passthrough, Stall = 0.
    - If the tag matches and the line is valid, the cached word is written at the edge.
    - A store miss does not allocate.
  - CpuRE & CpuWE together: store has priority. No fill starts. CpuRD = 0.
  - Idle (neither request): CpuRD = 0.
- FILL:
  - Stall = 1, CacheRA = miss_base, MemWE = 0. CpuWE is ignored (the CPU is stalled).
  - counter != 0: decrement.
  - counter == 0: at the edge, capture CacheLine into line[miss index], set the tag, set valid = 1, state -> IDLE.
  - The held request then hits in IDLE.
- Read miss penalty: FILL_LAT+1 stalled cycles, then one hit cycle.
- Outside FILL, CacheRA holds the last miss_base (0 after reset).
- Conflict miss: an index collision overwrites the resident line. No writeback is needed (write-through).
- Reset asserted mid-FILL: the fill is aborted, the target line stays invalid, and state = IDLE immediately.
- Line base is 64-byte aligned, so data_mem's CacheRD offsets never straddle lines. The memory size must be a multiple of 16 words.

Decomposition:
- Shared package holds:
  - WORDS_PER_LINE = 16
  - OFFSET_LSB = 2, INDEX_LSB = 6
  - state encoding IDLE = 1'b0, FILL = 1'b1
- Natural sub-module: dcache_line_store, the tag/valid/data array. It has:
  - a combinational read port (index, offset)
  - a single-word write port
  - a full-line write port with valid-set
  - an asynchronous clear of valid bits
- The FSM and passthrough logic stay in dcache_line_fill.

Test Plan:
- Reset, then load from 0x40 (data_mem word16 = 0xDEADBEEF, FILL_LAT=2) -> Stall high for 3 cycles, CacheRA = 0x40; next cycle CpuRD = 0xDEADBEEF, Stall = 0.
- After that fill, load from 0x7C -> hit, same cycle, CpuRD = data_mem word31, no stall.
- Store 0x12345678 to 0x44 (hit) -> MemWE = 1, MemWA = 0x44, MemWD = 0x12345678, no stall; next load from 0x44 returns 0x12345678 with no stall.
- Store to 0x400 (miss) -> MemWE pulse, no stall; a following load from 0x400 misses and fills.
- Load 0x40, then load 0x140 (same index 1 with NUM_LINES=4, tag differs), then load 0x40 again -> three separate fills, each with 3 stall cycles.
- Drop RST_N during the second FILL cycle -> Stall = 0 at once, state = IDLE; re-issued load from the same address misses again.
